rx_packet_controller: RTL and testbench

RX_PACKET_CONTROLLER -- requirements
Module: rx_packet_controller

---
 rtl/rx_packet_controller_if.sv | 32 +++
 rtl/rx_packet_controller.sv | 159 +++++++++++++++
 tb/tb_rx_packet_controller.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_packet_controller_if.sv
// Handshake and status bundle between the RX packet controller and its byte datapath.
interface rx_packet_controller_if;
    logic       d_edge;
    logic       eop;
    logic       byte_complete;
    logic [1:0] sync_status;
    logic [2:0] pid_status;
    logic [1:0] crc_status;
    logic       clear;
    logic       load_sync;
    logic       load_pid;
    logic       load_data;
    logic       check_sync;
    logic       check_pid;
    logic       crc_check_5;
    logic       crc_check_16;
    logic       load_error;
    logic       load_done;
    logic       rcving;

    modport master (
        input  d_edge, eop, byte_complete, sync_status, pid_status, crc_status,
        output clear, load_sync, load_pid, load_data, check_sync, check_pid,
               crc_check_5, crc_check_16, load_error, load_done, rcving
    );

    modport slave (
        output d_edge, eop, byte_complete, sync_status, pid_status, crc_status,
        input  clear, load_sync, load_pid, load_data, check_sync, check_pid,
               crc_check_5, crc_check_16, load_error, load_done, rcving
    );
endinterface

// File: rtl/rx_packet_controller.sv
// Receive-side packet sequencer: sync/PID/payload/CRC checking with done/error result.
// Optional inter-byte stall timeout enabled by defining RX_CTRL_TIMEOUT_EN.
module rx_packet_controller #(
    parameter int unsigned MAX_DATA_BYTES = 64,
    parameter int unsigned TIMEOUT_CYCLES = 512
) (
    input  logic                   clk,
    input  logic                   n_rst,
    rx_packet_controller_if.master bus
);
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned DATA_LIMIT = MAX_DATA_BYTES + 2;

    typedef enum logic [3:0] {
        IDLE, SYNC, SYNC_CHK, PID, PID_CHK, TOKEN, DATA, HSHAKE, CRC_CHK, DRAIN, DONE, ERR
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] byte_cnt, byte_cnt_n, cnt_inc;
    logic             crc16_sel, crc16_sel_n;
    logic             counting;
    logic             timeout_c;

    // Bytes landing in the same cycle as eop are counted before the eop decision.
    assign counting = state inside {TOKEN, DATA, HSHAKE};
    assign cnt_inc  = (counting && bus.byte_complete && (byte_cnt != '1))
                    ? byte_cnt + CNT_W'(1) : byte_cnt;

`ifdef RX_CTRL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] idle_cnt;
    logic             timed;

    assign timed = state inside {SYNC, PID, TOKEN, DATA, HSHAKE, DRAIN};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idle_cnt <= '0;
        end else if (!timed || bus.byte_complete) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TMO_W'(1);
        end
    end

    assign timeout_c = timed && !bus.byte_complete && (32'(idle_cnt) == TIMEOUT_CYCLES - 1);
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state and counter update.
    always_comb begin
        state_n     = state;
        byte_cnt_n  = cnt_inc;
        crc16_sel_n = crc16_sel;
        case (state)
            IDLE, DONE, ERR: begin
                if (bus.d_edge) state_n = SYNC;
            end
            SYNC: begin
                if (bus.eop)                state_n = ERR;
                else if (bus.byte_complete) state_n = SYNC_CHK;
            end
            SYNC_CHK: begin
                state_n = (bus.sync_status == 2'b01) ? PID : DRAIN;
            end
            PID: begin
                if (bus.eop)                state_n = ERR;
                else if (bus.byte_complete) state_n = PID_CHK;
            end
            PID_CHK: begin
                byte_cnt_n = '0;
                case (bus.pid_status)
                    3'b001, 3'b010: state_n = TOKEN;
                    3'b011:         state_n = HSHAKE;
                    3'b000:         state_n = DATA;
                    default:        state_n = DRAIN;
                endcase
            end
            TOKEN: begin
                if (bus.eop) begin
                    if (cnt_inc == CNT_W'(2)) begin
                        state_n     = CRC_CHK;
                        crc16_sel_n = 1'b0;
                    end else begin
                        state_n = ERR;
                    end
                end else if (cnt_inc >= CNT_W'(3)) begin
                    state_n = DRAIN;
                end
            end
            DATA: begin
                if (bus.eop) begin
                    if (cnt_inc < CNT_W'(2)) begin
                        state_n = ERR;
                    end else if (32'(cnt_inc) <= DATA_LIMIT) begin
                        state_n     = CRC_CHK;
                        crc16_sel_n = 1'b1;
                    end else begin
                        state_n = ERR;
                    end
                end else if (32'(cnt_inc) > DATA_LIMIT) begin
                    state_n = DRAIN;
                end
            end
            HSHAKE: begin
                if (bus.eop)                state_n = (cnt_inc == '0) ? DONE : ERR;
                else if (bus.byte_complete) state_n = DRAIN;
            end
            CRC_CHK: begin
                state_n = (bus.crc_status == 2'b01) ? DONE : ERR;
            end
            DRAIN: begin
                if (bus.eop) state_n = ERR;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // A stall only aborts when nothing else is moving the packet forward.
        if (timeout_c && (state_n == state)) state_n = ERR;
    end

    // State register plus outputs registered from the next state (Moore timing).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state            <= IDLE;
            byte_cnt         <= '0;
            crc16_sel        <= 1'b0;
            bus.clear        <= 1'b0;
            bus.load_sync    <= 1'b0;
            bus.load_pid     <= 1'b0;
            bus.load_data    <= 1'b0;
            bus.check_sync   <= 1'b0;
            bus.check_pid    <= 1'b0;
            bus.crc_check_5  <= 1'b0;
            bus.crc_check_16 <= 1'b0;
            bus.load_error   <= 1'b0;
            bus.load_done    <= 1'b0;
            bus.rcving       <= 1'b0;
        end else begin
            state            <= state_n;
            byte_cnt         <= byte_cnt_n;
            crc16_sel        <= crc16_sel_n;
            bus.clear        <= (state_n == SYNC) && (state != SYNC);
            bus.load_sync    <= (state_n == SYNC);
            bus.load_pid     <= (state_n == PID);
            bus.load_data    <= (state_n == DATA);
            bus.check_sync   <= (state_n == SYNC_CHK);
            bus.check_pid    <= (state_n == PID_CHK);
            bus.crc_check_5  <= (state_n == CRC_CHK) && !crc16_sel_n;
            bus.crc_check_16 <= (state_n == CRC_CHK) && crc16_sel_n;
            bus.load_error   <= (state_n == ERR);
            bus.load_done    <= (state_n == DONE);
            bus.rcving       <= !(state_n inside {IDLE, DONE, ERR});
        end
    end
endmodule

// File: tb/tb_rx_packet_controller.sv
// Scoreboard bench for rx_packet_controller: packet outcomes queued at stimulus, checked at packet end.
module tb_rx_packet_controller;
    localparam int unsigned MAX_DATA_BYTES = 64;
    localparam int unsigned TIMEOUT_CYCLES = 512;
    localparam int          DATA_LIMIT     = 66;

    // Output vector bit positions
    localparam logic [10:0] O_CLEAR = 11'b100_0000_0000;
    localparam logic [10:0] O_SYNC  = 11'b010_0000_0000;
    localparam logic [10:0] O_DATA  = 11'b000_1000_0000;
    localparam logic [10:0] O_ERR   = 11'b000_0000_0100;
    localparam logic [10:0] O_RCV   = 11'b000_0000_0001;

    typedef struct {
        logic done;
        logic err;
        int   c5;
        int   c16;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   c5_seen = 0;
    int   c16_seen = 0;
    int   c5_base = 0;
    int   c16_base = 0;
    exp_t sb[$];

    rx_packet_controller_if rx();

    rx_packet_controller #(
        .MAX_DATA_BYTES(MAX_DATA_BYTES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (rx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx.crc_check_5 === 1'b1)  c5_seen++;
        if (rx.crc_check_16 === 1'b1) c16_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    function automatic logic [10:0] outs();
        return {rx.clear, rx.load_sync, rx.load_pid, rx.load_data, rx.check_sync, rx.check_pid,
                rx.crc_check_5, rx.crc_check_16, rx.load_error, rx.load_done, rx.rcving};
    endfunction

    // Reference outcome derived from the packet rules, independent of the DUT.
    function automatic exp_t model(input logic [1:0] sync, input logic [2:0] pid,
                                   input int n, input logic [1:0] crc);
        exp_t e;
        logic crc_ok;
        crc_ok = (crc == 2'b01);
        e.done = 1'b0; e.err = 1'b1; e.c5 = 0; e.c16 = 0;
        if (sync == 2'b01) begin
            case (pid)
                3'b001, 3'b010: if (n == 2) begin
                    e.c5 = 1; e.done = crc_ok; e.err = !crc_ok;
                end
                3'b011: if (n == 0) begin
                    e.done = 1'b1; e.err = 1'b0;
                end
                3'b000: if (n >= 2 && n <= DATA_LIMIT) begin
                    e.c16 = 1; e.done = crc_ok; e.err = !crc_ok;
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_packet(input int tag, input logic [1:0] sync, input logic [2:0] pid);
        c5_base  = c5_seen;
        c16_base = c16_seen;
        rx.d_edge = 1'b1;
        tick();
        rx.d_edge = 1'b0;
        n_tests++;
        if (outs() !== (O_CLEAR | O_SYNC | O_RCV)) begin
            n_fail++;
            $display("FAIL pkt%0d_start: outputs=%b, required %b", tag, outs(), O_CLEAR | O_SYNC | O_RCV);
        end
        rx.sync_status   = sync;
        rx.byte_complete = 1'b1;
        tick();
        rx.byte_complete = 1'b0;
        tick();
        rx.pid_status    = pid;
        rx.byte_complete = 1'b1;
        tick();
        rx.byte_complete = 1'b0;
        tick();
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            rx.byte_complete = 1'b1;
            tick();
            rx.byte_complete = 1'b0;
            tick();
        end
    endtask

    task automatic end_packet(input logic with_byte);
        rx.byte_complete = with_byte;
        rx.eop = 1'b1;
        tick();
        rx.eop = 1'b0;
        rx.byte_complete = 1'b0;
    endtask

    task automatic collect(input int tag);
        exp_t e;
        int   k;
        k = 0;
        while (rx.rcving === 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_tests++;
        if (rx.rcving !== 1'b0) begin
            n_fail++;
            $display("FAIL pkt%0d_end: rcving=%b after %0d cycles, required 0", tag, rx.rcving, k);
        end
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL pkt%0d_sb: scoreboard empty, required one entry", tag);
        end else begin
            e = sb.pop_front();
            if ({rx.load_done, rx.load_error} !== {e.done, e.err} ||
                (c5_seen - c5_base) != e.c5 || (c16_seen - c16_base) != e.c16) begin
                n_fail++;
                $display("FAIL pkt%0d_result: done/err=%b%b crc5=%0d crc16=%0d, required %b%b crc5=%0d crc16=%0d",
                         tag, rx.load_done, rx.load_error, c5_seen - c5_base, c16_seen - c16_base,
                         e.done, e.err, e.c5, e.c16);
            end
        end
    endtask

    task automatic run_packet(input int tag, input logic [1:0] sync, input logic [2:0] pid,
                              input int n, input logic [1:0] crc, input logic same_cycle);
        sb.push_back(model(sync, pid, n, crc));
        rx.crc_status = crc;
        start_packet(tag, sync, pid);
        send_bytes(same_cycle ? n - 1 : n);
        end_packet(same_cycle);
        collect(tag);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (outs() !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_held: outputs=%b, required 0", outs());
        end
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        n_tests++;
        if (outs() !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_idle: outputs=%b, required 0", outs());
        end
    endtask

    task automatic test_token();
        run_packet(1, 2'b01, 3'b001, 2, 2'b01, 1'b0);
        run_packet(2, 2'b01, 3'b010, 2, 2'b00, 1'b0);
        run_packet(3, 2'b01, 3'b001, 3, 2'b01, 1'b0);
        run_packet(4, 2'b01, 3'b001, 1, 2'b01, 1'b0);
        run_packet(5, 2'b01, 3'b001, 2, 2'b01, 1'b1);
    endtask

    task automatic test_data();
        run_packet(10, 2'b01, 3'b000, 1, 2'b01, 1'b0);
        run_packet(11, 2'b01, 3'b000, 2, 2'b01, 1'b0);
        run_packet(12, 2'b01, 3'b000, 66, 2'b00, 1'b0);
        // Full-size packet with load_data observed at both ends of DATA
        sb.push_back(model(2'b01, 3'b000, 66, 2'b01));
        rx.crc_status = 2'b01;
        start_packet(13, 2'b01, 3'b000);
        n_tests++;
        if (outs() !== (O_DATA | O_RCV)) begin
            n_fail++;
            $display("FAIL data_enter: outputs=%b, required %b", outs(), O_DATA | O_RCV);
        end
        send_bytes(66);
        n_tests++;
        if (outs() !== (O_DATA | O_RCV)) begin
            n_fail++;
            $display("FAIL data_full: outputs=%b, required %b", outs(), O_DATA | O_RCV);
        end
        end_packet(1'b0);
        collect(13);
        // Oversize packet: drains after the 67th byte, error only after eop
        sb.push_back(model(2'b01, 3'b000, 67, 2'b01));
        start_packet(14, 2'b01, 3'b000);
        send_bytes(67);
        n_tests++;
        if (outs() !== O_RCV) begin
            n_fail++;
            $display("FAIL data_overflow_drain: outputs=%b, required %b", outs(), O_RCV);
        end
        end_packet(1'b0);
        collect(14);
    endtask

    task automatic test_bad_sync();
        sb.push_back(model(2'b10, 3'b001, 2, 2'b01));
        start_packet(20, 2'b10, 3'b001);
        send_bytes(2);
        n_tests++;
        if (outs() !== O_RCV) begin
            n_fail++;
            $display("FAIL sync_drain: outputs=%b, required %b", outs(), O_RCV);
        end
        rx.d_edge = 1'b1;
        tick();
        rx.d_edge = 1'b0;
        n_tests++;
        if (outs() !== O_RCV) begin
            n_fail++;
            $display("FAIL drain_dedge: outputs=%b, required %b", outs(), O_RCV);
        end
        end_packet(1'b0);
        collect(20);
        run_packet(21, 2'b01, 3'b100, 0, 2'b01, 1'b0);
    endtask

    task automatic test_handshake();
        run_packet(30, 2'b01, 3'b011, 0, 2'b01, 1'b0);
        run_packet(31, 2'b01, 3'b011, 1, 2'b01, 1'b0);
        run_packet(32, 2'b01, 3'b011, 1, 2'b01, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_packet(40, 2'b01, 3'b011, 0, 2'b01, 1'b0);
        run_packet(41, 2'b01, 3'b001, 2, 2'b01, 1'b0);
        run_packet(42, 2'b01, 3'b000, 4, 2'b01, 1'b0);
    endtask

    task automatic test_reset_mid();
        start_packet(50, 2'b01, 3'b000);
        send_bytes(5);
        #2;
        n_rst = 1'b0;
        #1;
        n_tests++;
        if (outs() !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: outputs=%b, required 0", outs());
        end
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        n_tests++;
        if (outs() !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: outputs=%b, required 0", outs());
        end
        run_packet(51, 2'b01, 3'b001, 2, 2'b01, 1'b0);
    endtask

    task automatic test_timeout();
        sb.push_back(model(2'b01, 3'b000, 0, 2'b01));
        rx.crc_status = 2'b01;
        start_packet(60, 2'b01, 3'b000);
        repeat (TIMEOUT_CYCLES - 1) tick();
        n_tests++;
        if (outs() !== (O_DATA | O_RCV)) begin
            n_fail++;
            $display("FAIL timeout_before: outputs=%b, required %b", outs(), O_DATA | O_RCV);
        end
        tick();
`ifdef RX_CTRL_TIMEOUT_EN
        n_tests++;
        if (outs() !== O_ERR) begin
            n_fail++;
            $display("FAIL timeout_fire: outputs=%b, required %b", outs(), O_ERR);
        end
`else
        repeat (88) tick();
        n_tests++;
        if (outs() !== (O_DATA | O_RCV)) begin
            n_fail++;
            $display("FAIL timeout_stall: outputs=%b, required %b", outs(), O_DATA | O_RCV);
        end
`endif
        end_packet(1'b0);
        collect(60);
    endtask

    initial begin
        rx.d_edge        = 1'b0;
        rx.eop           = 1'b0;
        rx.byte_complete = 1'b0;
        rx.sync_status   = 2'b00;
        rx.pid_status    = 3'b000;
        rx.crc_status    = 2'b00;
        test_reset();
        test_token();
        test_data();
        test_bad_sync();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
